// File: rtl/fcb_6_parametrised_skid_fifo.sv
// ============================================================================
//  Module   : fcb_6_parametrised_skid_fifo
//  Desc     : Depth-parametrised valid/ready buffer, all outputs from flops.
//             Optional occupancy port enabled by FCB_6_OCCUPANCY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fcb_6_parametrised_skid_fifo #(
  parameter int w     = 8,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         up_vld,
  output logic                         up_rdy,
  input  logic [w-1:0]                 up_data,
  output logic                         down_vld,
  input  logic                         down_rdy,
`ifdef FCB_6_OCCUPANCY_EN
  output logic [$clog2(depth+1)-1:0]   occupancy,
`endif
  output logic [w-1:0]                 down_data
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  localparam logic [PW-1:0] c_last_ptr = PW'(depth - 1);
  localparam logic [CW-1:0] c_full_cnt = CW'(depth);
  localparam logic [CW-1:0] c_one_cnt  = CW'(1);

  logic [w-1:0]  mem_q [depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          down_vld_q, down_vld_d;
  logic          up_rdy_q, up_rdy_d;

  logic w_push;
  logic w_pop;

  assign w_push = up_vld & up_rdy_q;
  assign w_pop  = down_vld_q & down_rdy;

  // Explicit wrap keeps pointers correct for non-power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_one_cnt;
      2'b01:   count_d = count_q - c_one_cnt;
      default: count_d = count_q;
    endcase
    down_vld_d = (count_d != '0);
    up_rdy_d   = (count_d != c_full_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      down_vld_q <= 1'b0;
      up_rdy_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      down_vld_q <= down_vld_d;
      up_rdy_q   <= up_rdy_d;
    end
  end

  // Storage is intentionally unreset; contents are only observed while valid.
  generate
    for (genvar i = 0; i < depth; i++) begin : g_mem
      always_ff @(posedge clk) begin
        if (w_push && (wr_ptr_q == PW'(i))) begin
          mem_q[i] <= up_data;
        end
      end
    end
  endgenerate

  assign down_data = mem_q[rd_ptr_q];
  assign down_vld  = down_vld_q;
  assign up_rdy    = up_rdy_q;

`ifdef FCB_6_OCCUPANCY_EN
  assign occupancy = count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fcb_6_parametrised_skid_fifo.sv
// ============================================================================
//  Module   : tb_fcb_6_parametrised_skid_fifo
//  Desc     : Self-checking bench: vector table, corner sequences, scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fcb_6_parametrised_skid_fifo;

  logic       clk = 1'b0;
  logic       rst;

  logic       u4_vld, u4_rdy, d4_vld, d4_rdy;
  logic [7:0] u4_data, d4_data;
  logic [2:0] occ4;

  logic       u3_vld, u3_rdy, d3_vld, d3_rdy;
  logic [7:0] u3_data, d3_data;
  logic [1:0] occ3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fcb_6_parametrised_skid_fifo #(.w(8), .depth(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (u4_vld),
    .up_rdy    (u4_rdy),
    .up_data   (u4_data),
    .down_vld  (d4_vld),
    .down_rdy  (d4_rdy),
`ifdef FCB_6_OCCUPANCY_EN
    .occupancy (occ4),
`endif
    .down_data (d4_data)
  );

  fcb_6_parametrised_skid_fifo #(.w(8), .depth(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (u3_vld),
    .up_rdy    (u3_rdy),
    .up_data   (u3_data),
    .down_vld  (d3_vld),
    .down_rdy  (d3_rdy),
`ifdef FCB_6_OCCUPANCY_EN
    .occupancy (occ3),
`endif
    .down_data (d3_data)
  );

`ifndef FCB_6_OCCUPANCY_EN
  assign occ4 = '0;
  assign occ3 = '0;
`endif

  typedef struct {
    logic       uv;
    logic [7:0] ud;
    logic       dr;
    logic       er;
    logic       ev;
    logic       cd;
    logic [7:0] ed;
    logic [2:0] eo;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] q4 [$];
  logic [7:0] q3 [$];
  bit         sb4_en = 1'b0;
  bit         sb3_en = 1'b0;
  int         pops4  = 0;
  logic       stall3_prev = 1'b0;
  logic [7:0] prev_data3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_occ4(input string name, input logic [2:0] exp);
`ifdef FCB_6_OCCUPANCY_EN
    chk(name, occ4, exp);
`endif
  endtask

  // Model flags derived from the bench's own queues, compared before update.
  task automatic sb_sample();
    logic [7:0] e;
    if (sb4_en) begin
      chk("sb4_vld", d4_vld, q4.size() != 0);
      chk("sb4_rdy", u4_rdy, q4.size() != 4);
`ifdef FCB_6_OCCUPANCY_EN
      chk("sb4_occ", occ4, q4.size());
`endif
      if (d4_vld && d4_rdy) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb4_underflow actual=pop required=none");
        end else begin
          e = q4.pop_front();
          chk("sb4_data", d4_data, e);
          pops4++;
        end
      end
      if (u4_vld && u4_rdy) q4.push_back(u4_data);
    end
    if (sb3_en) begin
      chk("sb3_vld", d3_vld, q3.size() != 0);
      chk("sb3_rdy", u3_rdy, q3.size() != 3);
`ifdef FCB_6_OCCUPANCY_EN
      chk("sb3_occ", occ3, q3.size());
`endif
      if (stall3_prev) begin
        chk("stall3_vld", d3_vld, 1);
        chk("stall3_data", d3_data, prev_data3);
      end
      stall3_prev = d3_vld && !d3_rdy;
      prev_data3  = d3_data;
      if (d3_vld && d3_rdy) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb3_underflow actual=pop required=none");
        end else begin
          e = q3.pop_front();
          chk("sb3_data", d3_data, e);
        end
      end
      if (u3_vld && u3_rdy) q3.push_back(u3_data);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    sb_sample();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  initial begin
    // uv  ud     dr  er  ev  cd  ed     eo
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 3'd1};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 3'd2};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 3'd3};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4};
    vecs[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

    rst = 1'b1;
    u4_vld = 0; u4_data = 0; d4_rdy = 0;
    u3_vld = 0; u3_data = 0; d3_rdy = 0;
    step(); step();
    sample();
    chk("reset_up_rdy", u4_rdy, 1);
    chk("reset_down_vld", d4_vld, 0);
    chk_occ4("reset_occ", 3'd0);
    step();
    rst = 1'b0;

    // Fill then drain via the vector table.
    for (int i = 0; i < 11; i++) begin
      u4_vld = vecs[i].uv; u4_data = vecs[i].ud; d4_rdy = vecs[i].dr;
      sample();
      chk($sformatf("vec%0d_up_rdy", i), u4_rdy, vecs[i].er);
      chk($sformatf("vec%0d_down_vld", i), d4_vld, vecs[i].ev);
      if (vecs[i].cd) chk($sformatf("vec%0d_data", i), d4_data, vecs[i].ed);
      chk_occ4($sformatf("vec%0d_occ", i), vecs[i].eo);
      step();
    end

    // Full + pop: the pop cycle must not accept a push.
    d4_rdy = 0; u4_vld = 1;
    for (int i = 0; i < 4; i++) begin
      u4_data = 8'hA1 + 8'(i);
      cyc();
    end
    u4_data = 8'hB5; d4_rdy = 1;
    sample();
    chk("fullpop_up_rdy", u4_rdy, 0);
    chk("fullpop_data", d4_data, 8'hA1);
    step();
    d4_rdy = 0;
    sample();
    chk("fullpop_next_up_rdy", u4_rdy, 1);
    chk("fullpop_next_data", d4_data, 8'hA2);
    chk_occ4("fullpop_next_occ", 3'd3);
    step();
    u4_vld = 0;
    sample();
    chk("fullpop_refull_up_rdy", u4_rdy, 0);
    chk_occ4("fullpop_refull_occ", 3'd4);
    step();
    d4_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("fullpop_drain%0d", i), d4_data, (i < 3) ? 8'hA2 + 8'(i) : 8'hB5);
      step();
    end
    d4_rdy = 0;
    sample();
    chk("fullpop_empty", d4_vld, 0);
    step();

    // Asynchronous reset with three words stored.
    u4_vld = 1;
    for (int i = 0; i < 3; i++) begin
      u4_data = 8'hC0 + 8'(i);
      cyc();
    end
    u4_vld = 0;
    sample();
    chk("prerst_vld", d4_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_vld", d4_vld, 0);
    chk("rst_async_rdy", u4_rdy, 1);
    chk_occ4("rst_async_occ", 3'd0);
    step();
    rst = 1'b0;
    u4_vld = 1; u4_data = 8'hD1;
    cyc();
    u4_vld = 0;
    sample();
    chk("postrst_vld", d4_vld, 1);
    chk("postrst_data", d4_data, 8'hD1);
    chk_occ4("postrst_occ", 3'd1);
    step();
    d4_rdy = 1;
    cyc();
    sample();
    chk("postrst_empty", d4_vld, 0);
    step();

    // Streaming 0..99 through depth 4.
    sb4_en = 1'b1;
    d4_rdy = 1; u4_vld = 1;
    for (int i = 0; i < 100; i++) begin
      u4_data = 8'(i);
      sample();
      if (i > 0) begin
        chk("stream_vld", d4_vld, 1);
        chk_occ4("stream_occ", 3'd1);
      end
      step();
    end
    u4_vld = 0;
    for (int i = 0; i < 4; i++) cyc();
    chk("stream_pops", pops4, 100);
    chk("stream_q_empty", q4.size(), 0);
    sb4_en = 1'b0;

    // Random traffic through depth 3.
    sb3_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      u3_vld  = 1'($urandom_range(0, 1));
      u3_data = 8'($urandom);
      d3_rdy  = 1'($urandom_range(0, 1));
      cyc();
    end
    u3_vld = 0; d3_rdy = 1;
    for (int i = 0; i < 5; i++) cyc();
    chk("rand_q_empty", q3.size(), 0);
    sb3_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
